// File: rtl/bsg_cache_dma_prefetch_arbiter.sv
// Shares one cache DMA engine between demand misses and stream prefetches; demand always wins.
// Optional macro BSG_CACHE_PF_PROMOTE_EN: a miss hitting an in-flight prefetch line takes it over.
module bsg_cache_dma_prefetch_arbiter #(
   parameter int addr_width_p          = 32,
   parameter int data_width_p          = 32,
   parameter int block_size_in_words_p = 8,
   parameter int pf_queue_els_p        = 2
) (
   input  logic                                            clk_i,
   input  logic                                            reset_i,
   input  logic                                            miss_v_i,
   input  logic [addr_width_p-1:0]                         miss_addr_i,
   output logic                                            miss_ready_o,
   input  logic                                            pf_v_i,
   input  logic [addr_width_p-1:0]                         pf_addr_i,
   output logic                                            pf_drop_o,
   output logic                                            dma_v_o,
   output logic [addr_width_p-1:0]                         dma_addr_o,
   input  logic                                            dma_ready_i,
   input  logic                                            dma_data_v_i,
   input  logic [data_width_p*block_size_in_words_p-1:0]   dma_data_i,
   output logic                                            miss_data_v_o,
   output logic                                            pf_data_v_o,
   output logic [data_width_p*block_size_in_words_p-1:0]   line_data_o,
   output logic                                            dma_busy_o
);

   localparam int          LW  = data_width_p * block_size_in_words_p;
   localparam int          BO  = $clog2(LW / 8);
   localparam int          TW  = addr_width_p - BO;
   localparam int unsigned ELS = pf_queue_els_p;
   localparam int          PW  = (pf_queue_els_p > 1) ? $clog2(pf_queue_els_p) : 1;
   localparam int          CW  = $clog2(pf_queue_els_p + 1);
   localparam logic [PW:0]   ELS_W  = (PW+1)'(pf_queue_els_p);
   localparam logic [CW-1:0] FULL_C = CW'(pf_queue_els_p);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_e;

   state_e          state_q, state_d;
   logic            owner_pf_q, owner_pf_d;
   logic [TW-1:0]   addr_q, addr_d;
   logic [ELS-1:0]  ent_v_q, ent_v_d;
   logic [TW-1:0]   ent_addr_q [ELS];
   logic [TW-1:0]   ent_addr_d [ELS];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   logic [TW-1:0]   miss_tag, pf_tag;
   logic            pop_found;
   logic [PW-1:0]   pop_sel, scan_idx;
   logic [CW-1:0]   pop_skip;
   logic            pf_dup, pf_drop, pf_enq, promote;
   logic            unused_low_bits;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
      logic [PW:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= ELS_W) s = s - ELS_W;
      return s[PW-1:0];
   endfunction

   assign miss_tag = miss_addr_i[addr_width_p-1:BO];
   assign pf_tag   = pf_addr_i[addr_width_p-1:BO];
   assign unused_low_bits = ^{miss_addr_i[BO-1:0], pf_addr_i[BO-1:0]};

   // Head scan: first valid entry within the occupied window; invalid ones ahead of it are consumed too.
   always_comb begin
      pop_found = 1'b0;
      pop_sel   = '0;
      pop_skip  = count_q;
      scan_idx  = '0;
      for (int unsigned i = 0; i < ELS; i++) begin
         scan_idx = wrap_add(head_q, PW'(i));
         if (!pop_found && (CW'(i) < count_q) && ent_v_q[scan_idx]) begin
            pop_found = 1'b1;
            pop_sel   = scan_idx;
            pop_skip  = CW'(i + 1);
         end
      end
   end

   always_comb begin
      pf_dup = 1'b0;
      for (int unsigned i = 0; i < ELS; i++) begin
         if (ent_v_q[i] && (ent_addr_q[i] == pf_tag)) pf_dup = 1'b1;
      end
      pf_drop = pf_v_i && ((count_q == FULL_C) || pf_dup
                           || ((state_q != S_IDLE) && (addr_q == pf_tag))
                           || (miss_v_i && (miss_tag == pf_tag)));
      pf_enq  = pf_v_i && !pf_drop;
   end

`ifdef BSG_CACHE_PF_PROMOTE_EN
   assign promote = (state_q != S_IDLE) && owner_pf_q && miss_v_i && (miss_tag == addr_q);
`else
   assign promote = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      owner_pf_d    = owner_pf_q;
      addr_d        = addr_q;
      ent_v_d       = ent_v_q;
      ent_addr_d    = ent_addr_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      miss_ready_o  = 1'b0;
      miss_data_v_o = 1'b0;
      pf_data_v_o   = 1'b0;

      if (promote) begin
         miss_ready_o = 1'b1;
         owner_pf_d   = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            if (miss_v_i) begin
               miss_ready_o = 1'b1;
               addr_d       = miss_tag;
               owner_pf_d   = 1'b0;
               state_d      = S_ISSUE;
               for (int unsigned i = 0; i < ELS; i++) begin
                  if (ent_addr_q[i] == miss_tag) ent_v_d[i] = 1'b0;
               end
            end else if (count_q != '0) begin
               // A window holding only squashed entries is drained without starting a transaction.
               head_d  = wrap_add(head_q, PW'(pop_skip));
               count_d = count_q - pop_skip;
               if (pop_found) begin
                  ent_v_d[pop_sel] = 1'b0;
                  addr_d           = ent_addr_q[pop_sel];
                  owner_pf_d       = 1'b1;
                  state_d          = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (dma_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dma_data_v_i) begin
               if (owner_pf_q && !promote) pf_data_v_o   = 1'b1;
               else                        miss_data_v_o = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pf_enq) begin
         ent_v_d[tail_q]    = 1'b1;
         ent_addr_d[tail_q] = pf_tag;
         tail_d             = wrap_add(tail_q, PW'(1));
         count_d            = count_d + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         owner_pf_q <= 1'b0;
         addr_q     <= '0;
         ent_v_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < ELS; i++) ent_addr_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         owner_pf_q <= owner_pf_d;
         addr_q     <= addr_d;
         ent_v_q    <= ent_v_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         for (int unsigned i = 0; i < ELS; i++) ent_addr_q[i] <= ent_addr_d[i];
      end
   end

   assign pf_drop_o   = pf_drop;
   assign dma_v_o     = (state_q == S_ISSUE);
   assign dma_addr_o  = {addr_q, {BO{1'b0}}};
   assign dma_busy_o  = (state_q != S_IDLE);
   assign line_data_o = (miss_data_v_o || pf_data_v_o) ? dma_data_i : '0;

endmodule

// File: tb/tb_bsg_cache_dma_prefetch_arbiter.sv
// Random-stimulus scoreboard bench for bsg_cache_dma_prefetch_arbiter (default parameters).
module tb_bsg_cache_dma_prefetch_arbiter;
   localparam int AW    = 32;
   localparam int LW    = 256;
   localparam int DEPTH = 2;

   logic          clk, reset_i;
   logic          miss_v_i, miss_ready_o, pf_v_i, pf_drop_o;
   logic [AW-1:0] miss_addr_i, pf_addr_i, dma_addr_o;
   logic          dma_v_o, dma_ready_i, dma_data_v_i;
   logic [LW-1:0] dma_data_i, line_data_o;
   logic          miss_data_v_o, pf_data_v_o, dma_busy_o;

   bsg_cache_dma_prefetch_arbiter #(
      .addr_width_p(32), .data_width_p(32), .block_size_in_words_p(8), .pf_queue_els_p(DEPTH)
   ) dut (
      .clk_i(clk), .reset_i(reset_i),
      .miss_v_i(miss_v_i), .miss_addr_i(miss_addr_i), .miss_ready_o(miss_ready_o),
      .pf_v_i(pf_v_i), .pf_addr_i(pf_addr_i), .pf_drop_o(pf_drop_o),
      .dma_v_o(dma_v_o), .dma_addr_o(dma_addr_o), .dma_ready_i(dma_ready_i),
      .dma_data_v_i(dma_data_v_i), .dma_data_i(dma_data_i),
      .miss_data_v_o(miss_data_v_o), .pf_data_v_o(pf_data_v_o),
      .line_data_o(line_data_o), .dma_busy_o(dma_busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct { logic [AW-1:0] a; bit v; } ent_t;
   typedef struct { bit rdy; bit drop; bit busy; bit dmav; } ctrl_t;
   typedef struct { bit dem; logic [LW-1:0] d; } dat_t;

   ent_t          mq[$];
   ctrl_t         exp_ctrl[$];
   logic [AW-1:0] exp_dma[$];
   dat_t          exp_dat[$];

   int total = 0;
   int bad   = 0;

   // Reference transaction state: one line in flight, whether the DMA took it, who owns it.
   bit            m_busy, m_req, m_dem;
   logic [AW-1:0] m_lat;
   bit            miss_pending, did_mid;
   logic [AW-1:0] cur_miss;

   function automatic bit lm(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return a[AW-1:5] == b[AW-1:5];
   endfunction

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return {a[AW-1:5], 5'b0};
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      return 32'h1000 + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
   endfunction

   function automatic logic [LW-1:0] rnd_line();
      logic [LW-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      ctrl_t c;
      ent_t  e;
      bit    dup, promote;
      dup = 0;
      promote = 0;
      foreach (mq[i]) if (mq[i].v && lm(mq[i].a, pf_addr_i)) dup = 1;
      c.drop = pf_v_i && ((mq.size() == DEPTH) || dup || (m_busy && lm(m_lat, pf_addr_i))
                          || (miss_v_i && lm(miss_addr_i, pf_addr_i)));
`ifdef BSG_CACHE_PF_PROMOTE_EN
      promote = m_busy && !m_dem && miss_v_i && lm(miss_addr_i, m_lat);
`endif
      c.rdy  = (!m_busy && miss_v_i) || promote;
      c.busy = m_busy;
      c.dmav = m_busy && !m_req;
      exp_ctrl.push_back(c);
      if (c.rdy) miss_pending = 0;
      if (promote) m_dem = 1;
      if (m_busy) begin
         if (!m_req) begin
            if (dma_ready_i) m_req = 1;
         end else if (dma_data_v_i) begin
            exp_dat.push_back('{m_dem, dma_data_i});
            m_busy = 0;
         end
      end else if (miss_v_i) begin
         m_busy = 1; m_req = 0; m_dem = 1;
         m_lat  = align(miss_addr_i);
         exp_dma.push_back(m_lat);
         foreach (mq[i]) if (lm(mq[i].a, miss_addr_i)) mq[i].v = 0;
      end else begin
         while (mq.size() > 0 && !mq[0].v) void'(mq.pop_front());
         if (mq.size() > 0) begin
            e = mq.pop_front();
            m_busy = 1; m_req = 0; m_dem = 0;
            m_lat  = align(e.a);
            exp_dma.push_back(m_lat);
         end
      end
      if (pf_v_i && !c.drop) mq.push_back('{pf_addr_i, 1'b1});
   endtask

   // Driver + reference model
   initial begin
      int  rst_left;
      bit  do_rst;
      reset_i = 1'b1; miss_v_i = 0; miss_addr_i = '0; pf_v_i = 0; pf_addr_i = '0;
      dma_ready_i = 0; dma_data_v_i = 0; dma_data_i = '0;
      m_busy = 0; m_req = 0; m_dem = 1; m_lat = '0;
      miss_pending = 0; cur_miss = '0; did_mid = 0; rst_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (!did_mid && cyc >= 2000 && m_busy && m_req) begin
            did_mid  = 1;
            rst_left = 2;
         end
         do_rst = (cyc < 2) || (rst_left > 0);
         if (rst_left > 0) rst_left--;
         if (do_rst) begin
            reset_i = 1; miss_v_i = 0; pf_v_i = 0;
            dma_ready_i = 1'($urandom_range(0, 1));
            dma_data_v_i = 1; dma_data_i = rnd_line();
            miss_pending = 0;
         end else begin
            reset_i = 0;
            if (!miss_pending && $urandom_range(0, 99) < 30) begin
               miss_pending = 1;
               cur_miss = rnd_addr();
            end
            miss_v_i    = miss_pending;
            miss_addr_i = cur_miss;
            pf_v_i      = ($urandom_range(0, 99) < 40);
            pf_addr_i   = rnd_addr();
            dma_ready_i = 1'($urandom_range(0, 1));
            if (m_busy && !m_req) dma_data_v_i = 0;
            else if (m_busy)      dma_data_v_i = ($urandom_range(0, 99) < 30);
            else                  dma_data_v_i = ($urandom_range(0, 99) < 10);
            dma_data_i = rnd_line();
         end
         #1;
         if (do_rst) begin
            m_busy = 0; m_req = 0; m_dem = 1;
            mq.delete();
            exp_dma.delete();
            exp_ctrl.push_back('{0, 0, 0, 0});
         end else begin
            model_step();
         end
      end
      #5;
      chk("reset_in_wait_reached", 1'(did_mid), 1'b1);
      chk("ctrl_queue_drained", exp_ctrl.size(), 0);
      chk("data_queue_drained", exp_dat.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Monitor: compares DUT outputs against whatever the model queued
   initial begin
      ctrl_t         c;
      dat_t          d;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         #2;
         if (exp_ctrl.size() == 0) begin
            chk("ctrl_expectation_present", 1'b0, 1'b1);
         end else begin
            c = exp_ctrl.pop_front();
            chk("miss_ready_o", miss_ready_o, c.rdy);
            chk("pf_drop_o", pf_drop_o, c.drop);
            chk("dma_busy_o", dma_busy_o, c.busy);
            chk("dma_v_o", dma_v_o, c.dmav);
         end
         if (dma_v_o && dma_ready_i) begin
            if (exp_dma.size() == 0) chk("dma_request_expected", 1'b1, 1'b0);
            else begin
               a = exp_dma.pop_front();
               chk("dma_addr_o", dma_addr_o, a);
            end
         end
         if (miss_data_v_o || pf_data_v_o) begin
            if (exp_dat.size() == 0) chk("data_pulse_expected", 1'b1, 1'b0);
            else begin
               d = exp_dat.pop_front();
               chk("miss_data_v_o", miss_data_v_o, d.dem);
               chk("pf_data_v_o", pf_data_v_o, !d.dem);
               chk("line_data_o", line_data_o, d.d);
            end
         end else if (exp_dat.size() != 0) begin
            d = exp_dat.pop_front();
            chk("data_pulse_missing", 1'b0, 1'b1);
         end
      end
   end

endmodule
